clock_set_ctrl: RTL and testbench

Mode/sequencing controller for the MM:SS clock datapath: one seconds mod-60 counter, one minutes mod-60 counter, and four 7-seg digits.
- Inputs: debounced single-cycle button pulses (CLR, MINUP, SECUP role-mapped to CLR, UP, MODE) and the 1 Hz enable pulse.
- Outputs: registered increment/clear strobes for both counters, digit blank masks and the colon drive.
- Operating modes: normal run, set-minutes and set-seconds.
- Set modes return to run automatically on an idle timeout.

---
 rtl/clock_set_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Mode and sequencing controller for an MM:SS clock datapath. It drives
// increment and clear strobes into an external seconds mod-60 counter and an
// external minutes mod-60 counter. It also generates the digit blank masks and
// the colon drive for the four 7-segment digits.
//
// Modes: RUN (normal timekeeping), SET_MIN and SET_SEC (manual editing).
// BMODE steps RUN -> SET_MIN -> SET_SEC -> RUN. A set mode falls back to RUN
// after TIMEOUT_SEC idle seconds. TIMEOUT_SEC = 0 disables that fallback.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous reset, active-low
//   EN1HZ      one-cycle pulse, once per second
//   BMODE      one-cycle pulse, mode button
//   BUP        one-cycle pulse, increment button
//   BCLR       one-cycle pulse, clear button
//   SEC_MAX    level, seconds counter currently equals 59
//   SEC_EN     one-cycle increment strobe to the seconds counter
//   MIN_EN     one-cycle increment strobe to the minutes counter
//   SEC_CLR    one-cycle synchronous clear to the seconds counter
//   MIN_CLR    one-cycle synchronous clear to the minutes counter
//   BLANK_SEC  1 = blank both seconds digits
//   BLANK_MIN  1 = blank both minutes digits
//   COLON      1 = colon segment lit
//   MODE       current state: 00 RUN, 01 SET_MIN, 10 SET_SEC
//
// Every output is a flop. Each strobe appears one cycle after the input cycle
// that qualifies it.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int TIMEOUT_SEC = 10,
  parameter int TMO_W       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       BMODE,
  input  logic       BUP,
  input  logic       BCLR,
  input  logic       SEC_MAX,
  output logic       SEC_EN,
  output logic       MIN_EN,
  output logic       SEC_CLR,
  output logic       MIN_CLR,
  output logic       BLANK_SEC,
  output logic       BLANK_MIN,
  output logic       COLON,
  output logic [1:0] MODE
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_SEC = 2'b10
  } state_t;

  // The last idle count before a forced return to RUN. This value is
  // meaningful only when the timeout is enabled.
  localparam bit               TMO_ENABLE = (TIMEOUT_SEC > 0);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_ENABLE ? TMO_W'(TIMEOUT_SEC - 1)
                                                       : {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] IDLE_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             phase_r;
  logic [TMO_W-1:0] idle_r;
  logic             sec_en_r, min_en_r, sec_clr_r, min_clr_r;
  logic             blank_sec_r, blank_min_r, colon_r;

  state_t           state_s;
  logic             phase_s;
  logic [TMO_W-1:0] idle_s;
  logic             sec_en_s, min_en_s, sec_clr_s, min_clr_s;
  logic             any_btn_s, in_set_s, next_set_s, tmo_hit_s;

  assign any_btn_s = BMODE | BUP | BCLR;
  assign in_set_s  = (state_r == ST_SET_MIN) || (state_r == ST_SET_SEC);
  // Any button press in the same cycle overrides the timeout.
  assign tmo_hit_s = TMO_ENABLE && (idle_r == TMO_LAST) && EN1HZ && !any_btn_s;

  // Next-state, strobe, blink-phase and idle-counter decode with button priority.
  always_comb begin
    state_s   = state_r;
    sec_en_s  = 1'b0;
    min_en_s  = 1'b0;
    sec_clr_s = 1'b0;
    min_clr_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (BMODE) begin
          state_s = ST_SET_MIN;
        end else if (BCLR) begin
          // A clear wins over a 1 Hz tick that arrives in the same cycle.
          sec_clr_s = 1'b1;
          min_clr_s = 1'b1;
        end else if (EN1HZ) begin
          // The minutes counter wraps from 59 to 0 by itself, so RUN only
          // needs to carry from seconds into minutes.
          sec_en_s = 1'b1;
          min_en_s = SEC_MAX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SET_MIN: begin
        if (BMODE) begin
          state_s = ST_SET_SEC;
        end else if (BCLR) begin
          min_clr_s = 1'b1;
        end else if (BUP) begin
          min_en_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SET_MIN;
        end
      end
      ST_SET_SEC: begin
        if (BMODE) begin
          state_s = ST_RUN;
        end else if (BCLR) begin
          sec_clr_s = 1'b1;
        end else if (BUP) begin
          // This edit has no carry: minutes stay fixed even when SEC_MAX is high.
          sec_en_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SET_SEC;
        end
      end
      default: begin
        // Encoding 11 is illegal. It recovers to RUN and drives no strobe.
        state_s = ST_RUN;
      end
    endcase

    next_set_s = (state_s == ST_SET_MIN) || (state_s == ST_SET_SEC);

    // Entering a set state, or editing inside one, forces the phase to 1.
    // This keeps the edited field visible straight away.
    if (next_set_s && (state_s != state_r)) begin
      phase_s = 1'b1;
    end else if (in_set_s && (BUP || BCLR)) begin
      phase_s = 1'b1;
    end else if (EN1HZ) begin
      phase_s = ~phase_r;
    end else begin
      phase_s = phase_r;
    end

    if ((state_s != state_r) || any_btn_s || !next_set_s) begin
      idle_s = {TMO_W{1'b0}};
    end else if (EN1HZ) begin
      idle_s = idle_r + IDLE_ONE;
    end else begin
      idle_s = idle_r;
    end
  end

  // Single state register. It holds the FSM, the blink phase, the idle counter
  // and every registered output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_RUN;
      phase_r     <= 1'b0;
      idle_r      <= {TMO_W{1'b0}};
      sec_en_r    <= 1'b0;
      min_en_r    <= 1'b0;
      sec_clr_r   <= 1'b0;
      min_clr_r   <= 1'b0;
      blank_sec_r <= 1'b0;
      blank_min_r <= 1'b0;
      colon_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      idle_r      <= idle_s;
      sec_en_r    <= sec_en_s;
      min_en_r    <= min_en_s;
      sec_clr_r   <= sec_clr_s;
      min_clr_r   <= min_clr_s;
      blank_sec_r <= (state_s == ST_SET_SEC) && !phase_s;
      blank_min_r <= (state_s == ST_SET_MIN) && !phase_s;
      colon_r     <= (state_s == ST_RUN) ? phase_s : 1'b1;
    end
  end

  assign SEC_EN    = sec_en_r;
  assign MIN_EN    = min_en_r;
  assign SEC_CLR   = sec_clr_r;
  assign MIN_CLR   = min_clr_r;
  assign BLANK_SEC = blank_sec_r;
  assign BLANK_MIN = blank_min_r;
  assign COLON     = colon_r;
  assign MODE      = state_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl. Two instances share the same inputs:
//   dut   TIMEOUT_SEC = 10
//   dut0  TIMEOUT_SEC = 0 (timeout disabled)
//
// Stimulus comes from a table of directed vectors, then from hand-written
// multi-cycle sequences: a 61-second count, the idle timeout, and an
// asynchronous reset during an edit.
//
// Output word layout: {SEC_EN, MIN_EN, SEC_CLR, MIN_CLR, BLANK_SEC, BLANK_MIN,
//                      COLON, MODE[1:0]}
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       en1hz, bmode, bup, bclr, sec_max;
  logic       sec_en, min_en, sec_clr, min_clr, blank_sec, blank_min, colon;
  logic [1:0] mode;
  logic       sec_en0, min_en0, sec_clr0, min_clr0, blank_sec0, blank_min0, colon0;
  logic [1:0] mode0;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(.TIMEOUT_SEC(10), .TMO_W(4)) dut (
    .CLK(clk), .RST(rst), .EN1HZ(en1hz), .BMODE(bmode), .BUP(bup), .BCLR(bclr),
    .SEC_MAX(sec_max), .SEC_EN(sec_en), .MIN_EN(min_en), .SEC_CLR(sec_clr),
    .MIN_CLR(min_clr), .BLANK_SEC(blank_sec), .BLANK_MIN(blank_min),
    .COLON(colon), .MODE(mode)
  );

  clock_set_ctrl #(.TIMEOUT_SEC(0), .TMO_W(4)) dut0 (
    .CLK(clk), .RST(rst), .EN1HZ(en1hz), .BMODE(bmode), .BUP(bup), .BCLR(bclr),
    .SEC_MAX(sec_max), .SEC_EN(sec_en0), .MIN_EN(min_en0), .SEC_CLR(sec_clr0),
    .MIN_CLR(min_clr0), .BLANK_SEC(blank_sec0), .BLANK_MIN(blank_min0),
    .COLON(colon0), .MODE(mode0)
  );

  logic [8:0] got, got0;
  assign got  = {sec_en, min_en, sec_clr, min_clr, blank_sec, blank_min, colon, mode};
  assign got0 = {sec_en0, min_en0, sec_clr0, min_clr0, blank_sec0, blank_min0, colon0, mode0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input word layout: {BMODE, BUP, BCLR, EN1HZ, SEC_MAX}
  typedef struct {
    logic [4:0] vin;
    logic [8:0] vexp;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one input word on the falling edge. Return 1 ns after the next
  // rising edge, when the registered outputs reflect that word.
  task automatic drive(input logic [4:0] v);
    @(negedge clk);
    {bmode, bup, bclr, en1hz, sec_max} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    {bmode, bup, bclr, en1hz, sec_max} = 5'b00000;
    @(posedge clk);
    #1;
    check("reset_state", got, 9'b0000_000_00);
    check("reset_state0", got0, 9'b0000_000_00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    int sec_total;
    int min_total;
    int min_at;

    rst = 1'b0;
    {bmode, bup, bclr, en1hz, sec_max} = 5'b00000;

    //             {bm,bu,bc,en,sm}   {se,me,sc,mc,bs,bmn,col,mode}
    vecs[0]  = '{5'b00000, 9'b0000_0_0_0_00}; // idle in RUN
    vecs[1]  = '{5'b00010, 9'b1000_0_0_1_00}; // tick -> SEC_EN, colon toggles
    vecs[2]  = '{5'b00011, 9'b1100_0_0_0_00}; // tick at 59 -> carry into minutes
    vecs[3]  = '{5'b00110, 9'b0011_0_0_1_00}; // clear beats tick
    vecs[4]  = '{5'b01000, 9'b0000_0_0_1_00}; // BUP ignored in RUN
    vecs[5]  = '{5'b10000, 9'b0000_0_0_1_01}; // enter SET_MIN, phase forced 1
    vecs[6]  = '{5'b00010, 9'b0000_0_1_1_01}; // tick frozen, blink off
    vecs[7]  = '{5'b00010, 9'b0000_0_0_1_01};
    vecs[8]  = '{5'b00010, 9'b0000_0_1_1_01};
    vecs[9]  = '{5'b01000, 9'b0100_0_0_1_01}; // BUP -> MIN_EN, re-forced visible
    vecs[10] = '{5'b01000, 9'b0100_0_0_1_01}; // back-to-back BUP
    vecs[11] = '{5'b01100, 9'b0001_0_0_1_01}; // BCLR beats BUP
    vecs[12] = '{5'b00110, 9'b0001_0_0_1_01}; // BCLR + tick: phase stays forced
    vecs[13] = '{5'b00011, 9'b0000_0_1_1_01}; // tick at 59 frozen
    vecs[14] = '{5'b11000, 9'b0000_0_0_1_10}; // BMODE beats BUP
    vecs[15] = '{5'b00010, 9'b0000_1_0_1_10}; // blink seconds
    vecs[16] = '{5'b01001, 9'b1000_0_0_1_10}; // BUP at 59: no MIN_EN
    vecs[17] = '{5'b01011, 9'b1000_0_0_1_10}; // BUP + tick: one SEC_EN only
    vecs[18] = '{5'b00100, 9'b0010_0_0_1_10}; // BCLR -> SEC_CLR only
    vecs[19] = '{5'b10000, 9'b0000_0_0_1_00}; // back to RUN, phase held
    vecs[20] = '{5'b00010, 9'b1000_0_0_0_00};
    vecs[21] = '{5'b10000, 9'b0000_0_0_1_01};
    vecs[22] = '{5'b10000, 9'b0000_0_0_1_10};
    vecs[23] = '{5'b10000, 9'b0000_0_0_1_00};

    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].vin);
      check($sformatf("vec%0d", i), got, vecs[i].vexp);
    end

    // 61 seconds in RUN. SEC_MAX comes from a bench-side seconds model.
    do_reset();
    cnt = 0;
    sec_total = 0;
    min_total = 0;
    min_at = 0;
    for (int i = 0; i < 61; i++) begin
      drive({4'b0001, (cnt == 59)});
      check($sformatf("count_sec_en%0d", i), {8'b0, sec_en}, 9'd1);
      check($sformatf("count_min_en%0d", i), {8'b0, min_en}, {8'b0, (cnt == 59)});
      if (sec_en) sec_total++;
      if (min_en) begin
        min_total++;
        min_at = sec_total;
      end
      cnt = (cnt == 59) ? 0 : cnt + 1;
      drive(5'b00000);
      check($sformatf("count_gap%0d", i), {7'b0, sec_en, min_en}, 9'd0);
    end
    check("count_sec_total", 9'(sec_total), 9'd61);
    check("count_min_total", 9'(min_total), 9'd1);
    check("count_min_at", 9'(min_at), 9'd60);

    // Idle timeout in SET_SEC. dut0 has the timeout disabled and must stay put.
    do_reset();
    drive(5'b10000);
    drive(5'b10000);
    for (int i = 0; i < 9; i++) drive(5'b00010);
    check("tmo_nine_mode", {7'b0, mode}, 9'd2);
    check("tmo_nine_mode0", {7'b0, mode0}, 9'd2);
    drive(5'b01000);
    for (int i = 0; i < 10; i++) begin
      drive(5'b00010);
      if (i < 9) begin
        check($sformatf("tmo_hold%0d", i), {7'b0, mode}, 9'd2);
      end else begin
        check("tmo_fire_mode", {7'b0, mode}, 9'd0);
        check("tmo_fire_nostrobe", {5'b0, sec_en, min_en, sec_clr, min_clr}, 9'd0);
      end
    end
    drive(5'b00010);
    check("tmo_disabled_mode0", {7'b0, mode0}, 9'd2);

    // Asynchronous reset in SET_SEC while BUP is pending.
    do_reset();
    drive(5'b10000);
    drive(5'b10000);
    drive(5'b01000);
    check("rst_pre", got, 9'b1000_0_0_1_10);
    @(negedge clk);
    bup = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", got, 9'd0);
    @(posedge clk);
    #1;
    check("rst_held", got, 9'd0);
    @(negedge clk);
    rst = 1'b1;
    bup = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'b00000);
      check($sformatf("rst_quiet%0d", i), got, 9'd0);
    end
    drive(5'b00010);
    check("rst_fresh", got, 9'b1000_0_0_1_00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
